// File: rtl/mem_latency_initiator.sv
// Request initiator for one port of the latency-configurable dual-port memory.
// Optional read-after-write address interlock: define MEMLAT_RAW_INTERLOCK_EN.
module mem_latency_initiator #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int RD_RETURN  = 6,
    parameter int WR_COMMIT  = 7,
    parameter int RSP_DEPTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_din,
    input  logic [DATA_WIDTH-1:0] i_mem_dout,
    output logic                  o_busy
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    logic [RD_RETURN-1:0]  rd_pipe;
    logic [WR_COMMIT-1:0]  wr_vld;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      fifo_count;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];

    logic accept;
    logic rd_accept;
    logic wr_accept;
    logic push;
    logic pop;
    logic credit_ok;
    logic raw_hit;

`ifdef MEMLAT_RAW_INTERLOCK_EN
    // Only writes issued fewer than WR_COMMIT edges ago can still hide a read.
    logic [ADDR_WIDTH-1:0] wr_addr [WR_COMMIT-1];

    always_comb begin
        raw_hit = 1'b0;
        for (int k = 0; k < WR_COMMIT - 1; k++) begin
            if (wr_vld[k] && (wr_addr[k] == i_req_addr)) begin
                raw_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        wr_addr[0] <= i_req_addr;
        for (int k = 1; k < WR_COMMIT - 1; k++) begin
            wr_addr[k] <= wr_addr[k-1];
        end
    end
`else
    assign raw_hit = 1'b0;
`endif

    always_comb begin
        pop         = (fifo_count != '0) && i_rsp_ready;
        push        = rd_pipe[RD_RETURN-1];
        credit_ok   = (outstanding < CNT_W'(RSP_DEPTH)) || pop;
        o_req_ready = i_rst_n && (i_req_we || (credit_ok && !raw_hit));
        accept      = i_req_valid && o_req_ready;
        rd_accept   = accept && !i_req_we;
        wr_accept   = accept && i_req_we;
        o_rsp_valid = (fifo_count != '0);
        o_rsp_rdata = o_rsp_valid ? fifo_mem[rd_ptr] : '0;
        o_busy      = (outstanding != '0) || (|wr_vld);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_mem_en   <= 1'b0;
            o_mem_we   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_din  <= '0;
        end else begin
            o_mem_en <= accept;
            o_mem_we <= wr_accept;
            if (accept) begin
                o_mem_addr <= i_req_addr;
                o_mem_din  <= i_req_wdata;
            end
        end
    end

    // Tracker starts on the edge the memory samples the read enable.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd_pipe <= '0;
            wr_vld  <= '0;
        end else begin
            rd_pipe <= {rd_pipe[RD_RETURN-2:0], o_mem_en && !o_mem_we};
            wr_vld  <= {wr_vld[WR_COMMIT-2:0], wr_accept};
        end
    end

    // Credit covers both in-flight reads and FIFO entries, so a push always has room.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            case ({rd_accept, pop})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= i_mem_dout;
        end
    end

endmodule
